// File: rtl/ccu_snoop_bcast.sv
// rtl/ccu_snoop_bcast.sv - snoop broadcast: AC fan-out, CR merge, CD forward/drain
//
// Snoop port vectors use flat field layouts:
//   request  [AcW+2:0] = {ac[AcW-1:0], ac_valid, cr_ready, cd_ready}
//   response [CdW+8:0] = {ac_ready, cr_valid, cr_resp[4:0], cd_valid, cd_data[CdW-1:0], cd_last}
//   cr_resp bits: [0] DataTransfer, [1] Error, [2] PassDirty, [3] IsShared, [4] WasUnique
// Per-master vectors concatenate the per-port fields, port 0 in the LSBs.
module ccu_snoop_bcast #(
    parameter int NoMst = 4,
    parameter int AcW   = 8,
    parameter int CdW   = 8,
    localparam int ReqW  = AcW + 3,
    localparam int RespW = CdW + 9
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [ReqW-1:0]        slv_snoop_req_i,
    output logic [RespW-1:0]       slv_snoop_resp_o,
    input  logic [NoMst-1:0]       domain_mask_i,
    output logic [NoMst*ReqW-1:0]  mst_snoop_reqs_o,
    input  logic [NoMst*RespW-1:0] mst_snoop_resps_i
);

    localparam int SelW = (NoMst > 1) ? $clog2(NoMst) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AC   = 3'd1,
        S_CR   = 3'd2,
        S_RESP = 3'd3,
        S_CD   = 3'd4
    } state_t;

    state_t           state, state_d;
    logic [AcW-1:0]   ac_q, ac_d;
    logic [NoMst-1:0] mask_q, mask_d;
    logic [NoMst-1:0] ac_done, ac_done_d;
    logic [NoMst-1:0] cr_done, cr_done_d;
    logic [NoMst-1:0] dt_vec, dt_d;
    logic [4:0]       cr_q, cr_d;
    logic [SelW-1:0]  sel_q, sel_d;

    // upstream request fields
    logic [AcW-1:0] s_ac;
    logic           s_ac_valid, s_cr_ready, s_cd_ready;
    assign s_ac       = slv_snoop_req_i[ReqW-1:3];
    assign s_ac_valid = slv_snoop_req_i[2];
    assign s_cr_ready = slv_snoop_req_i[1];
    assign s_cd_ready = slv_snoop_req_i[0];

    // upstream response fields
    logic           s_ac_ready, s_cr_valid, s_cd_valid, s_cd_last;
    logic [4:0]     s_cr_resp;
    logic [CdW-1:0] s_cd_data;
    assign slv_snoop_resp_o = {s_ac_ready, s_cr_valid, s_cr_resp, s_cd_valid, s_cd_data, s_cd_last};

    // per-master fields
    logic [NoMst-1:0] m_ac_ready, m_cr_valid, m_cd_valid, m_cd_last;
    logic [4:0]       m_cr_resp [NoMst];
    logic [CdW-1:0]   m_cd_data [NoMst];
    logic [NoMst-1:0] m_ac_valid, m_cr_ready, m_cd_ready;
    logic [AcW-1:0]   m_ac;

    for (genvar g = 0; g < NoMst; g++) begin : g_port
        assign m_cd_last[g]  = mst_snoop_resps_i[g*RespW];
        assign m_cd_data[g]  = mst_snoop_resps_i[g*RespW+1 +: CdW];
        assign m_cd_valid[g] = mst_snoop_resps_i[g*RespW+CdW+1];
        assign m_cr_resp[g]  = mst_snoop_resps_i[g*RespW+CdW+2 +: 5];
        assign m_cr_valid[g] = mst_snoop_resps_i[g*RespW+CdW+7];
        assign m_ac_ready[g] = mst_snoop_resps_i[g*RespW+CdW+8];
        assign mst_snoop_reqs_o[g*ReqW +: ReqW] = {m_ac, m_ac_valid[g], m_cr_ready[g], m_cd_ready[g]};
    end

    // the registered AC is only presented while the broadcast is in progress
    assign m_ac = (state == S_AC) ? ac_q : '0;

    // state and transaction registers, cleared immediately on reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            ac_q    <= '0;
            mask_q  <= '0;
            ac_done <= '0;
            cr_done <= '0;
            dt_vec  <= '0;
            cr_q    <= '0;
            sel_q   <= '0;
        end else begin
            state   <= state_d;
            ac_q    <= ac_d;
            mask_q  <= mask_d;
            ac_done <= ac_done_d;
            cr_done <= cr_done_d;
            dt_vec  <= dt_d;
            cr_q    <= cr_d;
            sel_q   <= sel_d;
        end
    end

    // next-state, handshake bookkeeping and port outputs
    always_comb begin
        state_d    = state;
        ac_d       = ac_q;
        mask_d     = mask_q;
        ac_done_d  = ac_done;
        cr_done_d  = cr_done;
        dt_d       = dt_vec;
        cr_d       = cr_q;
        sel_d      = sel_q;
        m_ac_valid = '0;
        m_cr_ready = '0;
        m_cd_ready = '0;
        s_ac_ready = 1'b0;
        s_cr_valid = 1'b0;
        s_cr_resp  = '0;
        s_cd_valid = 1'b0;
        s_cd_data  = '0;
        s_cd_last  = 1'b0;

        case (state)
            S_IDLE: begin
                s_ac_ready = 1'b1;
                if (s_ac_valid) begin
                    ac_d      = s_ac;
                    mask_d    = domain_mask_i;
                    ac_done_d = '0;
                    cr_done_d = '0;
                    dt_d      = '0;
                    cr_d      = '0;
                    state_d   = (domain_mask_i == '0) ? S_RESP : S_AC;
                end
            end

            S_AC, S_CR: begin
                // a port may answer CR as soon as its own AC is done, even
                // while other ports are still being offered the AC
                if (state == S_AC) begin
                    m_ac_valid = mask_q & ~ac_done;
                    m_cr_ready = mask_q & ac_done & ~cr_done;
                end else begin
                    m_cr_ready = mask_q & ~cr_done;
                end
                ac_done_d = ac_done | (m_ac_valid & m_ac_ready);
                for (int i = 0; i < NoMst; i++) begin
                    if (m_cr_ready[i] && m_cr_valid[i]) begin
                        cr_done_d[i] = 1'b1;
                        cr_d         = cr_d | m_cr_resp[i];
                        dt_d[i]      = m_cr_resp[i][0];
                    end
                end
                if (&(ac_done_d | ~mask_q)) begin
                    state_d = (&(cr_done_d | ~mask_q)) ? S_RESP : S_CR;
                end
            end

            S_RESP: begin
                s_cr_valid = 1'b1;
                s_cr_resp  = cr_q;
                if (s_cr_ready) begin
                    if (dt_vec == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        for (int i = NoMst - 1; i >= 0; i--) begin
                            if (dt_vec[i]) sel_d = SelW'(i);
                        end
                        state_d = S_CD;
                    end
                end
            end

            S_CD: begin
                // the selected port streams upstream; every other data port is drained
                s_cd_valid = dt_vec[sel_q] & m_cd_valid[sel_q];
                s_cd_data  = m_cd_data[sel_q];
                s_cd_last  = m_cd_last[sel_q];
                for (int i = 0; i < NoMst; i++) begin
                    if (dt_vec[i]) begin
                        m_cd_ready[i] = (SelW'(i) == sel_q) ? s_cd_ready : 1'b1;
                    end
                    if (m_cd_ready[i] && m_cd_valid[i] && m_cd_last[i]) begin
                        dt_d[i] = 1'b0;
                    end
                end
                if (dt_d == '0) state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// tb/tb_ccu_snoop_bcast.sv - directed table-driven bench for ccu_snoop_bcast
module tb_ccu_snoop_bcast;

    localparam int N   = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int RQW = AW + 3;
    localparam int RSW = DW + 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic [RQW-1:0]     slv_req;
    logic [RSW-1:0]     slv_resp;
    logic [N-1:0]       mask;
    logic [N*RQW-1:0]   mst_reqs;
    logic [N*RSW-1:0]   mst_resps;

    logic          u_ac_valid, u_cr_ready, u_cd_ready;
    logic [AW-1:0] u_ac;
    assign slv_req = {u_ac, u_ac_valid, u_cr_ready, u_cd_ready};

    wire          s_ac_ready = slv_resp[DW+8];
    wire          s_cr_valid = slv_resp[DW+7];
    wire [4:0]    s_cr_resp  = slv_resp[DW+6:DW+2];
    wire          s_cd_valid = slv_resp[DW+1];
    wire [DW-1:0] s_cd_data  = slv_resp[DW:1];

    logic [N-1:0]  p_ac_ready, p_cr_valid, p_cd_valid, p_cd_last;
    logic [4:0]    p_cr_resp [N];
    logic [DW-1:0] p_cd_data [N];

    always_comb begin
        mst_resps = '0;
        for (int i = 0; i < N; i++) begin
            mst_resps[i*RSW +: RSW] = {p_ac_ready[i], p_cr_valid[i], p_cr_resp[i],
                                       p_cd_valid[i], p_cd_data[i], p_cd_last[i]};
        end
    end

    ccu_snoop_bcast #(.NoMst(N), .AcW(AW), .CdW(DW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .slv_snoop_req_i   (slv_req),
        .slv_snoop_resp_o  (slv_resp),
        .domain_mask_i     (mask),
        .mst_snoop_reqs_o  (mst_reqs),
        .mst_snoop_resps_i (mst_resps)
    );

    function automatic logic d_acv(input int i); return mst_reqs[i*RQW+2]; endfunction
    function automatic logic d_crr(input int i); return mst_reqs[i*RQW+1]; endfunction
    function automatic logic d_cdr(input int i); return mst_reqs[i*RQW];   endfunction
    function automatic logic [AW-1:0] d_ac(input int i); return mst_reqs[i*RQW+3 +: AW]; endfunction

    function automatic logic [3*N-1:0] ctl_bits();
        logic [3*N-1:0] v;
        for (int i = 0; i < N; i++) v[i*3 +: 3] = {d_acv(i), d_crr(i), d_cdr(i)};
        return v;
    endfunction

    typedef struct {
        logic [N-1:0]      mask;
        logic [N-1:0][4:0] cr;
        logic [N-1:0][3:0] beats;
        logic [N-1:0][3:0] dly;
        int                cr_stall;
        bit                cd_toggle;
        logic [4:0]        exp_cr;
        int                exp_sel;
        int                exp_beats;
        bit                early_chk;
    } scen_t;

    function automatic scen_t mk(input logic [N-1:0] m, input logic [N*5-1:0] cr,
                                 input logic [N*4-1:0] beats, input logic [N*4-1:0] dly,
                                 input int stall, input bit tog, input logic [4:0] exp_cr,
                                 input int sel, input int nb, input bit early);
        scen_t s;
        s.mask = m; s.cr = cr; s.beats = beats; s.dly = dly;
        s.cr_stall = stall; s.cd_toggle = tog; s.exp_cr = exp_cr;
        s.exp_sel = sel; s.exp_beats = nb; s.early_chk = early;
        return s;
    endfunction

    scen_t tbl [6];
    scen_t cur;
    bit    active;
    int    phase [N];
    int    wait_c [N];
    int    beat [N];
    int    ac_cnt [N];
    int    cr_hs_step [N];
    int    ac_hs_step [N];
    logic [DW-1:0] rx_data [$];
    bit            rx_last [$];

    int passes = 0;
    int total  = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s[%0d] actual=%0h required=%0h", nm, id, act, exp);
    endtask

    // downstream master models: wait dly valid cycles before AC ready, then CR, then CD
    task automatic drive_ports();
        for (int i = 0; i < N; i++) begin
            if (!active) begin
                p_ac_ready[i] = 1'b0; p_cr_valid[i] = 1'b0; p_cr_resp[i] = '0;
                p_cd_valid[i] = 1'b0; p_cd_data[i] = '0; p_cd_last[i] = 1'b0;
            end else begin
                p_ac_ready[i] = (wait_c[i] >= int'(cur.dly[i]));
                p_cr_valid[i] = (phase[i] == 1) || !cur.mask[i];
                p_cr_resp[i]  = (phase[i] == 1) ? cur.cr[i] : (!cur.mask[i] ? 5'h1f : 5'h00);
                p_cd_valid[i] = (phase[i] == 2);
                p_cd_data[i]  = {4'(i), 4'(beat[i])};
                p_cd_last[i]  = (beat[i] == int'(cur.beats[i]) - 1);
            end
        end
    endtask

    task automatic run_scen(input int idx, input int abort_beats, output bit aborted);
        int step, up_ac_step, first_dac, last_cr, first_crv, crv_cnt;
        bit cr_done_f, done, stable_bad, rogue, ac_bad;
        logic [4:0] crv_val, got_cr;
        cur = tbl[idx];
        for (int i = 0; i < N; i++) begin
            phase[i] = 0; wait_c[i] = 0; beat[i] = 0; ac_cnt[i] = 0;
            cr_hs_step[i] = -1; ac_hs_step[i] = -1;
        end
        rx_data.delete(); rx_last.delete();
        up_ac_step = -1; first_dac = -1; last_cr = -1; first_crv = -1; crv_cnt = 0;
        cr_done_f = 0; done = 0; stable_bad = 0; rogue = 0; ac_bad = 0;
        crv_val = '0; got_cr = 5'h1f; aborted = 0;
        active = 1;
        mask = cur.mask;
        u_ac = 8'ha0 + 8'(idx);
        u_ac_valid = 1'b1;
        u_cr_ready = (cur.cr_stall == 0);
        u_cd_ready = 1'b1;
        step = 0;
        while (!done && step < 300) begin
            drive_ports();
            @(negedge clk);
            if (u_ac_valid && s_ac_ready && up_ac_step < 0) up_ac_step = step;
            for (int i = 0; i < N; i++) begin
                if (!cur.mask[i] && d_crr(i)) rogue = 1;
                if (cur.mask[i] && p_cr_valid[i] && d_crr(i)) begin
                    last_cr = step; cr_hs_step[i] = step;
                    phase[i] = (cur.cr[i][0] && cur.beats[i] != 0) ? 2 : 3;
                end
                if (p_cd_valid[i] && d_cdr(i)) begin
                    beat[i]++;
                    if (beat[i] == int'(cur.beats[i])) phase[i] = 3;
                end
                if (d_acv(i)) begin
                    if (first_dac < 0) first_dac = step;
                    if (d_ac(i) !== u_ac) ac_bad = 1;
                    if (p_ac_ready[i]) begin
                        ac_cnt[i]++; ac_hs_step[i] = step; phase[i] = 1;
                    end else begin
                        wait_c[i]++;
                    end
                end
            end
            if (s_cr_valid) begin
                if (first_crv < 0) begin
                    first_crv = step; crv_val = s_cr_resp;
                end else if (s_cr_resp !== crv_val) begin
                    stable_bad = 1;
                end
                if (u_cr_ready) begin
                    cr_done_f = 1; got_cr = s_cr_resp;
                end else begin
                    crv_cnt++;
                end
            end
            if (s_cd_valid && u_cd_ready) begin
                rx_data.push_back(s_cd_data);
                rx_last.push_back(slv_resp[0]);
                if (abort_beats >= 0 && rx_data.size() == abort_beats) begin
                    aborted = 1;
                    return;
                end
            end
            if (cr_done_f && s_ac_ready) done = 1;
            @(posedge clk); #1;
            step++;
            if (up_ac_step >= 0) u_ac_valid = 1'b0;
            u_cr_ready = !cr_done_f && (crv_cnt >= cur.cr_stall);
            if (cur.cd_toggle) u_cd_ready = ~u_cd_ready;
        end
        active = 0;
        drive_ports();
        u_ac_valid = 1'b0; u_cr_ready = 1'b0; u_cd_ready = 1'b0;

        chk("completed", idx, 32'(done), 32'd1);
        for (int i = 0; i < N; i++) chk("ac_count", idx*10+i, 32'(ac_cnt[i]), 32'(cur.mask[i]));
        chk("ac_forward", idx, 32'(ac_bad), 32'd0);
        chk("merged_cr", idx, 32'(got_cr), 32'(cur.exp_cr));
        chk("cr_stable", idx, 32'(stable_bad), 32'd0);
        chk("unmasked_cr_ready", idx, 32'(rogue), 32'd0);
        if (cur.mask != '0) begin
            chk("ac_latency", idx, 32'(first_dac), 32'(up_ac_step + 1));
            chk("cr_latency", idx, 32'(first_crv), 32'(last_cr + 1));
        end else begin
            chk("no_downstream_ac", idx, 32'(first_dac), 32'hffffffff);
            chk("empty_cr_latency", idx, 32'(first_crv), 32'(up_ac_step + 1));
        end
        chk("beat_count", idx, 32'(rx_data.size()), 32'(cur.exp_beats));
        for (int b = 0; b < rx_data.size() && b < cur.exp_beats; b++) begin
            chk("beat_data", idx*10+b, {23'd0, rx_last[b], rx_data[b]},
                {23'd0, (b == cur.exp_beats - 1), 4'(cur.exp_sel), 4'(b)});
        end
        if (cur.early_chk) chk("early_cr", idx, 32'(cr_hs_step[0] < ac_hs_step[2]), 32'd1);
    endtask

    initial begin
        bit ab;
        // {p3,p2,p1,p0} ordering in every packed field
        tbl[0] = mk(4'b0101, 20'd0, 16'h0000, 16'h0300, 0, 0, 5'b00000, 0, 0, 0);
        tbl[1] = mk(4'b1111, {5'b01001, 5'd0, 5'b00101, 5'd0}, 16'h4040, 16'h0000, 0, 0, 5'b01101, 1, 4, 0);
        tbl[2] = mk(4'b0000, 20'd0, 16'h0000, 16'h0000, 0, 0, 5'b00000, 0, 0, 0);
        tbl[3] = mk(4'b0011, {10'd0, 5'b10000, 5'b00001}, 16'h0003, 16'h0021, 5, 1, 5'b10001, 0, 3, 0);
        tbl[4] = mk(4'b0101, {5'd0, 5'b00001, 5'd0, 5'b00010}, 16'h0200, 16'h0500, 0, 0, 5'b00011, 2, 2, 1);
        tbl[5] = mk(4'b1000, {5'b00001, 15'd0}, 16'h1000, 16'h0000, 0, 0, 5'b00001, 3, 1, 0);

        active = 0;
        drive_ports();
        mask = '0; u_ac = '0; u_ac_valid = 0; u_cr_ready = 0; u_cd_ready = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_ac_ready", 0, 32'(s_ac_ready), 32'd1);
        chk("rst_cr_valid", 0, 32'(s_cr_valid), 32'd0);
        chk("rst_cd_valid", 0, 32'(s_cd_valid), 32'd0);
        chk("rst_port_ctl", 0, 32'(ctl_bits()), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 6; k++) run_scen(k, -1, ab);

        // reset pulse during the second CD beat of a data-carrying snoop
        run_scen(1, 1, ab);
        chk("abort_reached", 1, 32'(ab), 32'd1);
        @(posedge clk); #1;
        drive_ports();
        #1;
        chk("pre_reset_cd_valid", 1, 32'(s_cd_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ac_ready", 1, 32'(s_ac_ready), 32'd1);
        chk("arst_cr_valid", 1, 32'(s_cr_valid), 32'd0);
        chk("arst_cd_valid", 1, 32'(s_cd_valid), 32'd0);
        chk("arst_port_ctl", 1, 32'(ctl_bits()), 32'd0);
        active = 0;
        drive_ports();
        u_ac_valid = 0; u_cr_ready = 0; u_cd_ready = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_scen(1, -1, ab);
        run_scen(0, -1, ab);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
